// File: rtl/decoder_rr_arb_if.sv
// decoder_rr_arb_if -- request/grant bundle between requesters and the
// round-robin arbiter that drives a downstream 2-to-4 decoder.
//   req_in  : per-requester level-sensitive request lines
//   sel_out : registered binary index of the granted requester (decoder select)
//   en_out  : registered grant-valid flag (decoder enable)
// slave  = arbiter side, master = requester/decoder side.
interface decoder_rr_arb_if;
  logic [3:0] req_in;
  logic [1:0] sel_out;
  logic       en_out;

  modport slave  (input  req_in, output sel_out, output en_out);
  modport master (output req_in, input  sel_out, input  en_out);
endinterface

// File: rtl/decoder_rr_arb.sv
// decoder_rr_arb -- 4-way round-robin arbiter with bounded grant hold,
// producing a registered select/enable pair for a 2-to-4 decoder.
//   clk_in  : clock, all state updates on rising edge
//   rst_in  : asynchronous active-high reset
//   bus     : decoder_rr_arb_if.slave (req_in in, sel_out/en_out out)
// HOLD_CYCLES (1..16) bounds how many consecutive cycles one requester
// keeps the grant before the search moves past it.
module decoder_rr_arb #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  decoder_rr_arb_if.slave   bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [3:0] CNT_MAX = 4'(HOLD_CYCLES - 1);

  logic [0:0] r_state;
  logic [1:0] r_sel;
  logic       r_en;
  logic [3:0] r_cnt;
  logic [1:0] r_last;

  logic [1:0] w_pick;
  logic       w_found;
  logic [1:0] w_idx;
  logic       w_release;
  logic       w_expire;
  logic       w_end;
  logic       w_any;

  assign w_any = |bus.req_in;

  // Search starts one past the last grant and wraps; i = 4 lands back on
  // r_last itself, so a lone requester is re-granted after expiry.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last;
    w_idx   = r_last;
    for (int i = 1; i <= 4; i++) begin
      w_idx = r_last + 2'(i);
      if (!w_found && bus.req_in[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_release = !bus.req_in[r_sel];
  assign w_expire  = (r_cnt == CNT_MAX);
  assign w_end     = w_release || w_expire;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_sel   <= 2'b00;
      r_en    <= 1'b0;
      r_cnt   <= 4'd0;
      r_last  <= 2'b11;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= GRANT;
            r_sel   <= w_pick;
            r_last  <= w_pick;
            r_en    <= 1'b1;
            r_cnt   <= 4'd0;
          end
        end
        GRANT: begin
          if (w_end) begin
            r_cnt <= 4'd0;
            if (w_any) begin
              // back-to-back hand-over, enable stays high
              r_sel  <= w_pick;
              r_last <= w_pick;
            end else begin
              // sel holds its last value while idle
              r_state <= IDLE;
              r_en    <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_en    <= 1'b0;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign bus.sel_out = r_sel;
  assign bus.en_out  = r_en;

endmodule

// File: tb/tb_decoder_rr_arb.sv
module tb_decoder_rr_arb;

  logic clk_in = 1'b0;
  logic rst_in;
  int   total = 0;
  int   bad   = 0;

  decoder_rr_arb_if bus ();

  decoder_rr_arb #(.HOLD_CYCLES(4)) u_dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] es, input logic ee);
    total++;
    assert ({bus.sel_out, bus.en_out} === {es, ee}) else begin
      bad++;
      $error("FAIL %s: sel=%0d en=%0b expected sel=%0d en=%0b",
             tag, bus.sel_out, bus.en_out, es, ee);
    end
  endtask

  task automatic rst_pulse();
    @(negedge clk_in);
    bus.req_in = 4'b0000;
    rst_in = 1'b1;
    #1;
    rst_in = 1'b0;
  endtask

  int full_seq [17];

  initial begin
    full_seq = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
    rst_in     = 1'b1;
    bus.req_in = 4'b0000;

    // reset state
    #2;
    chk("rst_state", 2'd0, 1'b0);
    tick();
    tick();
    chk("rst_held", 2'd0, 1'b0);

    // first grant after reset: search starts at 0
    @(negedge clk_in);
    rst_in     = 1'b0;
    bus.req_in = 4'b0101;
    tick();
    chk("rst_first", 2'd0, 1'b1);

    // release of 0 hands over to 2 without a bubble
    bus.req_in = 4'b0100;
    tick();
    chk("rel_to2", 2'd2, 1'b1);

    // async reset mid-grant, checked before the next edge
    #2;
    rst_in = 1'b1;
    #1;
    chk("rst_async", 2'd0, 1'b0);
    bus.req_in = 4'b0000;
    @(negedge clk_in);
    rst_in = 1'b0;
    tick();
    chk("idle", 2'd0, 1'b0);

    // single requester: continuous grant to 2 across re-grants
    bus.req_in = 4'b0100;
    for (int i = 0; i < 13; i++) begin
      tick();
      chk($sformatf("single_%0d", i), 2'd2, 1'b1);
    end

    // drain to idle, sel holds 2
    bus.req_in = 4'b0000;
    tick();
    chk("drain_from2", 2'd2, 1'b0);
    tick();
    chk("idle_hold2", 2'd2, 1'b0);

    // pointer wrap: last = 2, order 3,0,1,2
    bus.req_in = 4'b0101;
    tick();
    chk("wrap_ptr", 2'd0, 1'b1);

    // full load from reset
    rst_pulse();
    bus.req_in = 4'b1111;
    for (int i = 0; i < 17; i++) begin
      tick();
      chk($sformatf("full_%0d", i), 2'(full_seq[i]), 1'b1);
    end

    // drain during grant to 3
    rst_pulse();
    bus.req_in = 4'b1000;
    tick();
    chk("g3_a", 2'd3, 1'b1);
    tick();
    chk("g3_b", 2'd3, 1'b1);
    bus.req_in = 4'b0000;
    tick();
    chk("drain_from3", 2'd3, 1'b0);
    bus.req_in = 4'b1001;
    tick();
    chk("after_drain", 2'd0, 1'b1);

    // early release of 0 after two grant cycles, then full hold on 1
    rst_pulse();
    bus.req_in = 4'b0011;
    tick();
    chk("er_g0_a", 2'd0, 1'b1);
    tick();
    chk("er_g0_b", 2'd0, 1'b1);
    bus.req_in = 4'b0010;
    tick();
    chk("er_g1_0", 2'd1, 1'b1);
    bus.req_in = 4'b0011;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("er_g1_%0d", i), 2'd1, 1'b1);
    end
    tick();
    chk("er_expire", 2'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    bad++;
    $display("FAIL timeout: run did not complete, expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
